// File: rtl/ps2_kbd_rx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - scan-code prefix bytes (E0 = extended key, F0 = key release)
//   - frame FSM state encoding
//   - keyboard FIFO entry layout {ext, brk, code}
//   - frame_ok(): stop-bit and odd-parity acceptance test for a frame
// ---------------------------------------------------------------------------
package ps2_kbd_rx_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int KBD_ENTRY_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_entry_t;

    // A frame is good when the stop bit is high and the eight data bits plus
    // the parity bit hold an odd number of ones.
    function automatic logic frame_ok(input logic [7:0] code,
                                      input logic       parity,
                                      input logic       stop);
        return stop & (^{code, parity});
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_fifo.sv
// ---------------------------------------------------------------------------
// kbd_fifo
// Synchronous FIFO holding decoded key entries. Storage is registered, the
// head entry is read combinationally so the CPU sees it without a fetch cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset (flushes the FIFO)
//   push, din     write request and data; dropped when full unless a pop
//                 happens in the same cycle
//   pop           remove head entry; ignored when empty
//   full, empty   occupancy flags
//   head          current head entry (undefined content when empty)
// ---------------------------------------------------------------------------
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == (AW+1)'(DEPTH));

    // When full, a simultaneous pop frees the slot the push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver for the bus keyboard read port. Synchronises the raw
// PS/2 pins, glitch-filters the PS/2 clock, assembles 11-bit frames on its
// falling edges, folds E0/F0 prefixes into flags and queues {ext,brk,code}.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   rd_pop     one-cycle pulse: pop FIFO head
//   key_out    {valid, brk, code}; zero when FIFO empty
//   key_ext    E0 flag of head entry; zero when FIFO empty
//   overflow   sticky: an entry was dropped on a full FIFO
//   frame_err  one-cycle pulse: bad parity or stop bit
// ---------------------------------------------------------------------------
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_pop,
    output logic [9:0] key_out,
    output logic       key_ext,
    output logic       overflow,
    output logic       frame_err
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    // ---------------- 2-FF synchronisers (bit 0 = clock, bit 1 = data) ----
    logic [1:0] pins_raw;
    logic [1:0] pins_sync;

    assign pins_raw = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Reset to the idle (high) bus level so no false edge follows reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= pins_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign pins_sync[gi] = sync_reg;
        end
    endgenerate

    logic clk_sync;
    logic data_sync;

    assign clk_sync  = pins_sync[0];
    assign data_sync = pins_sync[1];

    // ---------------- ps2_clk glitch filter -------------------------------
    logic              clk_filt_reg, clk_filt_next;
    logic [FILT_W-1:0] filt_cnt_reg, filt_cnt_next;
    logic              fe;

    // The counter tracks consecutive samples disagreeing with the filtered
    // level; any agreeing sample restarts it.
    always_comb begin
        clk_filt_next = clk_filt_reg;
        filt_cnt_next = filt_cnt_reg;
        fe            = 1'b0;
        if (clk_sync == clk_filt_reg) begin
            filt_cnt_next = '0;
        end else if (filt_cnt_reg == FILT_W'(FILTER_LEN - 1)) begin
            clk_filt_next = clk_sync;
            filt_cnt_next = '0;
            fe            = clk_filt_reg;
        end else begin
            filt_cnt_next = filt_cnt_reg + FILT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_reg <= 1'b1;
            filt_cnt_reg <= '0;
        end else begin
            clk_filt_reg <= clk_filt_next;
            filt_cnt_reg <= filt_cnt_next;
        end
    end

    // ---------------- frame FSM, prefix decoder, timeout ------------------
    frame_state_t      state_reg, state_next;
    logic [2:0]        bit_cnt_reg, bit_cnt_next;
    logic [7:0]        shift_reg, shift_next;
    logic              parity_reg, parity_next;
    logic              ext_reg, ext_next;
    logic              brk_reg, brk_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              frame_err_reg, frame_err_next;
    logic              push;
    kbd_entry_t        push_entry;

    assign push_entry = '{ext: ext_reg, brk: brk_reg, code: shift_reg};

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        parity_next    = parity_reg;
        ext_next       = ext_reg;
        brk_next       = brk_reg;
        frame_err_next = 1'b0;
        push           = 1'b0;

        // Idle time is only measured inside a frame.
        if (state_reg == ST_IDLE || fe) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
        end

        if (fe) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!data_sync) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {data_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_next = data_sync;
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (frame_ok(shift_reg, parity_reg, data_sync)) begin
                        if (shift_reg == PS2_PREFIX_EXT) begin
                            ext_next = 1'b1;
                        end else if (shift_reg == PS2_PREFIX_BRK) begin
                            brk_next = 1'b1;
                        end else begin
                            push     = 1'b1;
                            ext_next = 1'b0;
                            brk_next = 1'b0;
                        end
                    end else begin
                        // A corrupted frame invalidates any pending prefix.
                        frame_err_next = 1'b1;
                        ext_next       = 1'b0;
                        brk_next       = 1'b0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state_reg != ST_IDLE &&
                     to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Stalled frame: drop it silently, pending prefixes survive.
            state_next  = ST_IDLE;
            to_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'd0;
            parity_reg    <= 1'b0;
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            to_cnt_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_reg    <= parity_next;
            ext_reg       <= ext_next;
            brk_reg       <= brk_next;
            to_cnt_reg    <= to_cnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // ---------------- key FIFO and outputs --------------------------------
    logic             fifo_full;
    logic             fifo_empty;
    logic [KBD_ENTRY_W-1:0] fifo_head;
    kbd_entry_t       head_entry;
    logic             overflow_reg;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KBD_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (rd_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign head_entry = fifo_head;

    // Full implies non-empty, so a concurrent rd_pop always makes room.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (push && fifo_full && !rd_pop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign key_out   = fifo_empty ? 10'd0 : {1'b1, head_entry.brk, head_entry.code};
    assign key_ext   = ~fifo_empty & head_entry.ext;
    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
module tb_ps2_kbd_rx;

    localparam int HALF     = 20;    // PS/2 half bit period in clk cycles
    localparam int FILT     = 8;
    localparam int TO       = 1000;  // scaled-down frame timeout
    localparam int NVEC     = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_pop;
    logic [9:0] key_out;
    logic       key_ext;
    logic       overflow;
    logic       frame_err;

    int n_checks   = 0;
    int n_fail     = 0;
    int err_pulses = 0;

    logic [10:0] exp_q[$];   // {ext, key_out} expected at FIFO head, in order

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FIFO_DEPTH     (16),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_pop    (rd_pop),
        .key_out   (key_out),
        .key_ext   (key_ext),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    // Counts every cycle frame_err is high, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (frame_err) err_pulses++;
    end

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       stop;
        logic       exp_push;
        logic [9:0] exp_key;
        logic       exp_ext;
        int         exp_err;
        logic       drain_after;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] code,
                                             input logic bad_par,
                                             input logic stop);
        return {stop, (~^code) ^ bad_par, code, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(frame[i]);
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop);
        send_bits(mk_frame(code, bad_par, stop), 11);
        idle_cycles(60);
    endtask

    task automatic check_head(input string name);
        if (exp_q.size() == 0) check(name, {21'd0, key_ext, key_out}, 32'd0);
        else                   check(name, {21'd0, key_ext, key_out}, {21'd0, exp_q[0]});
    endtask

    task automatic pop_one();
        rd_pop = 1'b1;
        @(negedge clk);
        rd_pop = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            check_head($sformatf("%s_pop%0d", name, k));
            void'(exp_q.pop_front());
            pop_one();
            k++;
        end
        check_head($sformatf("%s_empty", name));
    endtask

    initial begin
        int e0;
        logic [7:0] cb;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 10'h21C, 1'b0, 0, 1'b1};
        vecs[1]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 0, 1'b0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 10'h31C, 1'b0, 0, 1'b1};
        vecs[3]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 0, 1'b0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 0, 1'b0};
        vecs[5]  = '{8'h75, 1'b0, 1'b1, 1'b1, 10'h375, 1'b1, 0, 1'b1};
        vecs[6]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 1, 1'b1};
        vecs[7]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 0, 1'b0};
        vecs[8]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1, 1'b0};
        vecs[9]  = '{8'h5A, 1'b0, 1'b1, 1'b1, 10'h25A, 1'b0, 0, 1'b1};
        vecs[10] = '{8'h15, 1'b0, 1'b1, 1'b1, 10'h215, 1'b0, 0, 1'b0};
        vecs[11] = '{8'h16, 1'b0, 1'b1, 1'b1, 10'h216, 1'b0, 0, 1'b1};

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_pop   = 1'b0;
        idle_cycles(5);
        check("rst_key_out",   {22'd0, key_out}, 32'd0);
        check("rst_key_ext",   {31'd0, key_ext}, 32'd0);
        check("rst_overflow",  {31'd0, overflow}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        idle_cycles(20);

        // Pop while empty must not disturb the FIFO.
        pop_one();
        check_head("pop_on_empty");

        for (int v = 0; v < NVEC; v++) begin
            e0 = err_pulses;
            send_frame(vecs[v].code, vecs[v].bad_par, vecs[v].stop);
            if (vecs[v].exp_push) exp_q.push_back({vecs[v].exp_ext, vecs[v].exp_key});
            check($sformatf("vec%0d_frame_err", v), err_pulses - e0, vecs[v].exp_err);
            check_head($sformatf("vec%0d_head", v));
            if (vecs[v].drain_after) drain($sformatf("vec%0d", v));
        end

        // Overflow: 17 codes into a 16-deep FIFO, the last is dropped.
        check("ovf_before", {31'd0, overflow}, 32'd0);
        for (int c = 1; c <= 17; c++) begin
            cb = 8'(c);
            send_frame(cb, 1'b0, 1'b1);
            if (c <= 16) exp_q.push_back({1'b0, 1'b1, 1'b0, cb});
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        drain("ovf");
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Partial frame then a stalled clock: the frame is abandoned quietly.
        e0 = err_pulses;
        send_bits(mk_frame(8'hAA, 1'b0, 1'b1), 6);
        idle_cycles(TO + 50);
        check("to_no_err", err_pulses - e0, 32'd0);
        check_head("to_no_entry");
        send_frame(8'h29, 1'b0, 1'b1);
        exp_q.push_back({1'b0, 10'h229});
        check_head("to_next_frame");
        drain("to");

        // A pending E0 prefix survives a timeout.
        send_frame(8'hE0, 1'b0, 1'b1);
        send_bits(mk_frame(8'h55, 1'b0, 1'b1), 4);
        idle_cycles(TO + 50);
        send_frame(8'h29, 1'b0, 1'b1);
        exp_q.push_back({1'b1, 10'h229});
        check_head("to_keeps_prefix");
        drain("to_pfx");

        // Short ps2_clk glitches with data low while idle: nothing starts.
        e0 = err_pulses;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ps2_data = 1'b0;
            ps2_clk  = 1'b0;
            @(negedge clk);
            ps2_clk  = 1'b1;
            idle_cycles(30);
        end
        ps2_clk = 1'b0;
        idle_cycles(FILT - 2);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        idle_cycles(30);
        check("glitch_no_err", err_pulses - e0, 32'd0);
        check_head("glitch_no_entry");
        send_frame(8'h33, 1'b0, 1'b1);
        exp_q.push_back({1'b0, 10'h233});
        check_head("glitch_next_frame");
        drain("glitch");

        // Reset in the middle of a frame with a queued entry.
        send_frame(8'h44, 1'b0, 1'b1);
        exp_q.push_back({1'b0, 10'h244});
        check_head("pre_rst_entry");
        send_bits(mk_frame(8'h55, 1'b0, 1'b1), 4);
        rst = 1'b1;
        idle_cycles(3);
        rst = 1'b0;
        exp_q.delete();
        check_head("midrst_flushed");
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        exp_q.push_back({1'b0, 10'h21C});
        check_head("midrst_next_frame");
        drain("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
